// File: rtl/soc_cpu_1_oci_dct_packer.sv
// Packs 2-bit trace frames into 15-slot capture words and hands them to the trace sink.
// Also sequences the end-of-test flush and reports when the captured trace has drained.
module soc_cpu_1_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic [1:0]  frame_data,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [29:0] word_data,
    output logic [3:0]  word_count,
    output logic        overflow,
    output logic        test_has_ended
);

    logic        flushing;
    logic        out_free;
    logic        launch;
    logic        accept;
    logic        append;
    logic        drop;
    logic [29:0] buf_next;
    logic [3:0]  cnt_next;

    assign out_free = !word_valid || word_ready;
    assign launch   = ((dct_count == 4'd15) || (flushing && (dct_count != 4'd0))) && out_free;
    assign accept   = word_valid && word_ready;
    // The cycle that first sees test_ending already ignores incoming frames.
    assign append   = frame_valid && !flushing && !test_ending;

    always_comb begin
        buf_next = launch ? 30'd0 : dct_buffer;
        cnt_next = launch ? 4'd0  : dct_count;
        drop     = 1'b0;
        if (append) begin
            if (cnt_next != 4'd15) begin
                buf_next[{cnt_next, 1'b0} +: 2] = frame_data;
                cnt_next = cnt_next + 4'd1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer     <= '0;
            dct_count      <= '0;
            word_valid     <= 1'b0;
            word_data      <= '0;
            word_count     <= '0;
            overflow       <= 1'b0;
            test_has_ended <= 1'b0;
            flushing       <= 1'b0;
        end else begin
            // A launch refills the output register even when the old word is accepted now.
            if (launch) begin
                word_data  <= dct_buffer;
                word_count <= dct_count;
                word_valid <= 1'b1;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
            dct_buffer <= buf_next;
            dct_count  <= cnt_next;
            if (drop)
                overflow <= 1'b1;
            if (test_ending)
                flushing <= 1'b1;
            if (flushing && (dct_count == 4'd0) && !word_valid)
                test_has_ended <= 1'b1;
        end
    end

endmodule
